// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle multiply/divide unit with HI/LO registers.
// Runs a shift-add multiply or a restoring divide, one iteration per cycle,
// and commits the result to HI/LO on the edge that enters DONE.
// Optional feature: define MULDIV_SIGNED_EN to enable two's-complement
// operands. Magnitudes are taken at issue, and a FIX cycle restores the signs.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mf_req,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic             dbz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 op_div_q, op_div_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH:0]       rem_q, rem_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic                 dbz_q, dbz_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mult_sum;
    logic [2*WIDTH-1:0]   mult_next;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic                 div_ok;
    logic [WIDTH:0]       rem_next;
    logic [WIDTH-1:0]     quo_next;

`ifdef MULDIV_SIGNED_EN
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;

    assign a_mag = a[WIDTH-1] ? -a : a;
    assign b_mag = b[WIDTH-1] ? -b : b;
`else
    assign a_mag = a;
    assign b_mag = b;
`endif

    // One iteration of each algorithm: acc holds the product (multiplier in the low half), or the quotient in its low half for divide.
    always_comb begin
        mult_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, dvs_q};
        mult_next = acc_q[0] ? {mult_sum, acc_q[WIDTH-1:1]}
                             : {1'b0, acc_q[2*WIDTH-1:1]};
        div_shift = (rem_q << 1) | {{WIDTH{1'b0}}, acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, dvs_q};
        div_ok    = ~div_diff[WIDTH];
        rem_next  = div_ok ? div_diff : div_shift;
        quo_next  = {acc_q[WIDTH-2:0], div_ok};
    end

    // Next-state and register updates; HI/LO change only on the edge into DONE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_div_d = op_div_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        dbz_d    = dbz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
`ifdef MULDIV_SIGNED_EN
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_div_d = op_div;
                    cnt_d    = '0;
                    dbz_d    = 1'b0;
`ifdef MULDIV_SIGNED_EN
                    neg_res_d = a[WIDTH-1] ^ b[WIDTH-1];
                    neg_rem_d = a[WIDTH-1];
`endif
                    if (op_div && (b == '0)) begin
                        dbz_d   = 1'b1;
                        hi_d    = a;
                        lo_d    = '1;
                        state_d = DONE;
                    end else begin
                        dvs_d   = op_div ? b_mag : a_mag;
                        acc_d   = {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
                        rem_d   = '0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (op_div_q) begin
                    rem_d = rem_next;
                    acc_d = {acc_q[2*WIDTH-1:WIDTH], quo_next};
                end else begin
                    acc_d = mult_next;
                end
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef MULDIV_SIGNED_EN
                    state_d = FIX;
`else
                    if (op_div_q) begin
                        hi_d = rem_next[WIDTH-1:0];
                        lo_d = quo_next;
                    end else begin
                        hi_d = mult_next[2*WIDTH-1:WIDTH];
                        lo_d = mult_next[WIDTH-1:0];
                    end
                    state_d = DONE;
`endif
                end
            end
`ifdef MULDIV_SIGNED_EN
            FIX: begin
                if (op_div_q) begin
                    lo_d = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                end else begin
                    {hi_d, lo_d} = neg_res_q ? -acc_q : acc_q;
                end
                state_d = DONE;
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_div_q <= 1'b0;
            acc_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            dbz_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef MULDIV_SIGNED_EN
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_div_q <= op_div_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            dbz_q    <= dbz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
`ifdef MULDIV_SIGNED_EN
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign stall = busy & mf_req;
    assign dbz   = dbz_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: scoreboard bench for muldiv_sequencer (unsigned build).
module tb_muldiv_sequencer;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          doneCyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        mf_req;
    logic        busy;
    logic        done;
    logic        stall;
    logic        dbz;
    logic [31:0] hi;
    logic [31:0] lo;

    int   cyc = 0;
    int   vectorsApplied = 0;
    int   miscompares = 0;
    exp_t sb[$];

    muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_div (op_div),
        .a      (a),
        .b      (b),
        .mf_req (mf_req),
        .busy   (busy),
        .done   (done),
        .stall  (stall),
        .dbz    (dbz),
        .hi     (hi),
        .lo     (lo)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Count rising edges so the monitor can measure completion latency.
    always @(posedge clk) cyc <= cyc + 1;

    // Single comparison point: every check bumps the vector count, and every mismatch bumps the miscompare count.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectorsApplied++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Architectural reference: full product, or quotient/remainder, or the divide-by-zero convention.
    function automatic void model(input bit opDiv, input logic [31:0] opA, input logic [31:0] opB,
                                  output exp_t e, output int lat);
        logic [63:0] prod;
        e.doneCyc = 0;
        if (!opDiv) begin
            prod  = {32'b0, opA} * {32'b0, opB};
            e.hi  = prod[63:32];
            e.lo  = prod[31:0];
            e.dbz = 1'b0;
            lat   = 33;
        end else if (opB == 32'd0) begin
            e.hi  = opA;
            e.lo  = 32'hFFFF_FFFF;
            e.dbz = 1'b1;
            lat   = 1;
        end else begin
            e.hi  = opA % opB;
            e.lo  = opA / opB;
            e.dbz = 1'b0;
            lat   = 33;
        end
    endfunction

    // Issue one operation, push its expected result, and optionally inject an ignored start and mf_req probes.
    task automatic applyStimulus(input bit opDiv, input logic [31:0] opA, input logic [31:0] opB, input bit interfere);
        exp_t e;
        int   lat;
        int   t0;
        int   k;
        int   guard;
        guard = 0;
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (busy) checkOutput("idle_timeout", 64'(busy), 64'(0));
        @(negedge clk);
        model(opDiv, opA, opB, e, lat);
        t0 = cyc;
        e.doneCyc = t0 + lat;
        start  = 1'b1;
        op_div = opDiv;
        a      = opA;
        b      = opB;
        sb.push_back(e);
        k = 0;
        do begin
            @(negedge clk);
            k = cyc - t0;
            if (k == 1) begin
                start  = 1'b0;
                op_div = 1'($urandom);
                a      = $urandom;
                b      = $urandom;
                checkOutput("busy_cycle1", 64'(busy), 64'(1));
                checkOutput("dbz_cycle1", 64'(dbz), 64'(e.dbz));
            end
            if (k == lat) checkOutput("busy_last", 64'(busy), 64'(1));
            if (interfere) begin
                if (k == 5) begin
                    start  = 1'b1;
                    op_div = 1'b1;
                    b      = 32'd0;
                end
                if (k == 6) start = 1'b0;
                if (k == 10 || k == 33 || k == 34) begin
                    mf_req = 1'b1;
                    #1;
                    checkOutput($sformatf("stall_cycle%0d", k), 64'(stall), 64'(k != 34));
                end else begin
                    mf_req = 1'b0;
                end
            end
        end while (busy && k < 60);
        mf_req = 1'b0;
        if (busy) checkOutput("done_timeout", 64'(busy), 64'(0));
        checkOutput("hold_hi", 64'(hi), 64'(e.hi));
        checkOutput("hold_lo", 64'(lo), 64'(e.lo));
    endtask

    // Monitor: whenever done is presented, pop the oldest expectation and compare result and latency.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_done", 64'(done), 64'(0));
            end else begin
                e = sb.pop_front();
                checkOutput("hi", 64'(hi), 64'(e.hi));
                checkOutput("lo", 64'(lo), 64'(e.lo));
                checkOutput("dbz", 64'(dbz), 64'(e.dbz));
                checkOutput("done_cycle", 64'(cyc), 64'(e.doneCyc));
            end
        end
    end

    // Guard against a hung simulation.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, directed cases, mid-operation reset, then random traffic.
    initial begin
        int t0;
        rst    = 1'b1;
        start  = 1'b0;
        op_div = 1'b0;
        a      = 32'd0;
        b      = 32'd0;
        mf_req = 1'b1;
        #12;
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_done", 64'(done), 64'(0));
        checkOutput("reset_dbz", 64'(dbz), 64'(0));
        checkOutput("reset_hi", 64'(hi), 64'(0));
        checkOutput("reset_lo", 64'(lo), 64'(0));
        checkOutput("reset_stall", 64'(stall), 64'(0));
        mf_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(1'b0, 32'd7, 32'd6, 1'b0);
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        applyStimulus(1'b1, 32'd100, 32'd7, 1'b0);
        applyStimulus(1'b1, 32'd1234, 32'd0, 1'b0);
        applyStimulus(1'b0, $urandom, $urandom, 1'b0);
        applyStimulus(1'b0, $urandom, $urandom, 1'b1);

        // Reset in the middle of a divide must clear everything at once, without a commit.
        while (busy) @(negedge clk);
        @(negedge clk);
        t0     = cyc;
        start  = 1'b1;
        op_div = 1'b1;
        a      = $urandom;
        b      = $urandom_range(1, 1000);
        @(negedge clk);
        start = 1'b0;
        while (cyc - t0 < 12) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_busy", 64'(busy), 64'(0));
        checkOutput("async_rst_done", 64'(done), 64'(0));
        checkOutput("async_rst_hi", 64'(hi), 64'(0));
        checkOutput("async_rst_lo", 64'(lo), 64'(0));
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, $urandom, $urandom_range(1, 65535), 1'b0);

        for (int i = 0; i < 24; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 255));
                default: rb = $urandom;
            endcase
            applyStimulus(1'($urandom), ra, rb, 1'b0);
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
